// File: rtl/fpu_div_sequencer.sv
// Radix-2 non-restoring mantissa divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + pre_dividend,
//   divisor in; out_valid/out_ready + quotient, remainder, div_by_zero out.
module fpu_div_sequencer #(
  parameter int DIVIDEND_LENGTH = 25,
  parameter int DIVISOR_LENGTH  = 24,
  parameter int QUOTIENT_LENGTH = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIVIDEND_LENGTH-1:0] pre_dividend,
  input  logic [DIVISOR_LENGTH-1:0]  divisor,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [QUOTIENT_LENGTH-1:0] quotient,
  output logic [DIVISOR_LENGTH-1:0]  remainder,
  output logic                       div_by_zero
);

  localparam int N  = DIVIDEND_LENGTH;
  localparam int CW = $clog2(N + 1);
  localparam int PW = DIVISOR_LENGTH + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [PW-1:0]              r_p;
  logic [N-1:0]               r_a;
  logic [DIVISOR_LENGTH-1:0]  r_v;
  logic [CW-1:0]              r_cnt;
  logic [QUOTIENT_LENGTH-1:0] r_q;
  logic [DIVISOR_LENGTH-1:0]  r_r;
  logic                       r_dbz;

  logic          w_zero;
  logic          w_last;
  logic [PW-1:0] w_vext;
  logic [PW-1:0] w_shift;
  logic [PW-1:0] w_p_next;
  logic [PW-1:0] w_p_fix;

  assign w_zero = (divisor == '0);
  assign w_last = (r_cnt == CW'(N - 1));
  assign w_vext = {1'b0, r_v};

  // Since -V <= P < V, the shifted value can wrap past PW bits,
  // but the add/sub result always lands back in range, so the
  // modulo-2^PW arithmetic is exact. Sign is the MSB of P.
  assign w_shift  = {r_p[PW-2:0], r_a[N-1]};
  assign w_p_next = r_p[PW-1] ? (w_shift + w_vext)
                              : (w_shift - w_vext);
  assign w_p_fix  = r_p[PW-1] ? (r_p + w_vext) : r_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next = w_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) begin
          w_next = S_FIX;
        end
      end
      S_FIX: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p   <= '0;
      r_a   <= '0;
      r_v   <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= pre_dividend;
            r_v   <= divisor;
            r_p   <= '0;
            r_cnt <= '0;
            if (w_zero) begin
              r_q   <= '1;
              r_r   <= pre_dividend[DIVISOR_LENGTH-1:0];
              r_dbz <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_p   <= w_p_next;
          r_a   <= {r_a[N-2:0], ~w_p_next[PW-1]};
          r_cnt <= r_cnt + CW'(1);
        end
        S_FIX: begin
          r_p   <= w_p_fix;
          r_q   <= r_a;
          r_r   <= w_p_fix[DIVISOR_LENGTH-1:0];
          r_dbz <= 1'b0;
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign quotient    = r_q;
  assign remainder   = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: doc/fpu_div_sequencer.md
Name: fpu_div_sequencer

Overview:
- Multi-cycle, radix-2, non-restoring sequencer for the FPU divide path.
- Accepts a 25-bit pre-normalised dividend and a 24-bit divisor, each aligned the same way as the mantissa divide datapath.
- Iterates one quotient bit per clock.
- Performs a final remainder correction and returns quotient and remainder through a valid/ready handshake.
- Replaces the combinational array divider wherever area matters more than latency; the FPU top instantiates it between mantissa alignment and quotient normalisation.

Parameters:
- DIVIDEND_LENGTH, 25, dividend width; also the number of iterations (N).
- DIVISOR_LENGTH, 24, divisor and remainder width.
- QUOTIENT_LENGTH, 25, quotient width; must equal DIVIDEND_LENGTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands are valid.
- in_ready  out  1  sequencer is idle and able to accept operands.
- pre_dividend  in  DIVIDEND_LENGTH  unsigned dividend.
- divisor  in  DIVISOR_LENGTH  unsigned divisor.
- out_valid  out  1  result is valid; held until consumed.
- out_ready  in  1  consumer accepts the result.
- quotient  out  QUOTIENT_LENGTH  floor(pre_dividend / divisor).
- remainder  out  DIVISOR_LENGTH  pre_dividend mod divisor.
- div_by_zero  out  1  divisor was 0; qualified by out_valid.

Behaviour:
- Interface decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0, partial remainder P=0.
- rst asserted in any state, including mid-CALC, aborts the operation on that edge and returns to the reset values. No result is produced for the aborted operation.
- Internal registers:
  - P: signed, DIVISOR_LENGTH+1 bits.
  - A: dividend shift register, DIVIDEND_LENGTH bits.
  - V: latched divisor.
  - cnt: ceil(log2(N+1)) bits.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, on that edge: latch A=pre_dividend, V=divisor, P=0, cnt=0.
  - If divisor==0, go to DONE with quotient = all ones, remainder = pre_dividend[DIVISOR_LENGTH-1:0], div_by_zero=1.
  - Otherwise go to CALC.
- CALC, one iteration per edge:
  - Form {P,A} shifted left by 1.
  - If the old P >= 0: P = shifted P - V. Else: P = shifted P + V.
  - Shift new quotient bit = ~P_new[MSB] into the LSB of A.
  - cnt += 1.
  - When cnt reaches N-1 on an edge, the next state is FIX (exactly N CALC edges).
- FIX (one edge):
  - If P < 0, P += V.
  - quotient = A; remainder = P[DIVISOR_LENGTH-1:0]; div_by_zero=0.
  - Go to DONE.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are stable.
  - On out_ready, go to IDLE on that edge and drop out_valid.
  - If out_ready is held high continuously, out_valid lasts exactly one cycle.
- in_ready=0 in CALC, FIX and DONE. in_valid is ignored there and operands are not sampled; the upstream block must hold them.
- Latency: a handshake on edge k makes out_valid high after edge k+N+2 (k+1 for divide-by-zero). Throughput is one operation per N+3 cycles when out_ready is tied high.
- No back-to-back acceptance in DONE: a new operand is taken only in IDLE, the cycle after the result is consumed.
- Outputs are registered only; no combinational path from in_valid or out_ready to any output.
- Arithmetic:
  - P never exceeds DIVISOR_LENGTH+1 bits because |P| < 2V at all times.
  - The quotient is exact for any nonzero divisor, including divisor=1 (quotient = dividend) and dividend < divisor (quotient = 0).

Test Plan:
- pre_dividend=25'h0851230, divisor=24'h800953, out_ready=1 → out_valid 27 cycles after the handshake; quotient=25'h0000001, remainder=24'h0508DD, div_by_zero=0.
- pre_dividend=25'h0100000, divisor=24'hB00000 → quotient=0, remainder=24'h100000 (dividend < divisor).
- pre_dividend=25'h1FFFFFF, divisor=24'h000001 → quotient=25'h1FFFFFF, remainder=0. Also pre_dividend=25'h1000000, divisor=24'h800000 → quotient=2, remainder=0.
- divisor=0, pre_dividend=25'h0851230 → out_valid on the next cycle; quotient=25'h1FFFFFF, remainder=24'h851230, div_by_zero=1.
- out_ready held low for 5 cycles in DONE → out_valid and data stay constant; in_valid pulses are ignored (in_ready=0). Raising out_ready then produces IDLE the next cycle, and a new operand is accepted.
- rst asserted during CALC at iteration 10 → next cycle all outputs are at reset values and in_ready=1. A following operation (25'h0851230 / 24'h800953) returns the correct result.
